// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI responder: FSM state encoding,
// protocol widths and the channel-select helper over the flat sample bus.
package mcp3008_pkg;

    localparam int ADC_BITS = 10;
    localparam int CMD_BITS = 4;
    localparam int NUM_CH   = 8;
    localparam int BUS_W    = ADC_BITS * NUM_CH;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ST,
        CMD,
        SNAP,
        NULL,
        MSB,
        LSB,
        ZERO
    } state_t;

    // CHk lives at bus[10*k+9 -: 10].
    function automatic logic [ADC_BITS-1:0] ch_sel(input logic [BUS_W-1:0] bus,
                                                   input logic [2:0]       k);
        logic [6:0] base;
        base = 7'(k) * 7'(ADC_BITS);
        return bus[base +: ADC_BITS];
    endfunction

endpackage

// File: rtl/mcp3008_spi_responder_if.sv
// SPI pin bundle between an MCP3008 master and the responder.
// The master owns sck/cs/mosi; the responder drives miso and its output enable.
interface mcp3008_spi_responder_if;
    logic spi_sck;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck,
        output spi_cs,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for the asynchronous SPI pins plus SCK edge detection
// in the clk domain.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_n_s,
    output logic o_mosi_s
);
    localparam int TOP = SYNC_STAGES - 1;

    logic [TOP:0] r_sck_sync;
    logic [TOP:0] r_cs_sync;
    logic [TOP:0] r_mosi_sync;
    logic         r_sck_d;

    // cs resets to "selected" so a frame already in progress at reset release
    // can never look like a fresh cs-high-then-low sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[TOP-1:0], i_sck};
            r_cs_sync   <= {r_cs_sync[TOP-1:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[TOP-1:0], i_mosi};
            r_sck_d     <= r_sck_sync[TOP];
        end
    end

    assign o_sck_rise = r_sck_sync[TOP] & ~r_sck_d;
    assign o_sck_fall = ~r_sck_sync[TOP] & r_sck_d;
    assign o_cs_n_s   = r_cs_sync[TOP];
    assign o_mosi_s   = r_mosi_sync[TOP];

endmodule

// File: rtl/mcp3008_spi_responder.sv
// SPI mode-0 responder emulating an MCP3008: decodes start/SGL/D2..D0, snapshots
// the selected (or differential) sample and shifts it out MSB-first then LSB-first.
module mcp3008_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADC_BITS    = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [mcp3008_pkg::BUS_W-1:0] i_ch_data,
    mcp3008_spi_responder_if.slave        spi,
    output logic                          o_req_valid,
    output logic [2:0]                    o_req_chan,
    output logic                          o_req_sgl,
    output logic                          o_frame_done,
    output mcp3008_pkg::state_t           o_state
);
    import mcp3008_pkg::*;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_n_s;
    logic w_mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sck      (spi.spi_sck),
        .i_cs_n     (spi.spi_cs),
        .i_mosi     (spi.spi_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_n_s   (w_cs_n_s),
        .o_mosi_s   (w_mosi_s)
    );

    state_t                r_state,      w_state_nxt;
    logic [3:0]            r_bitcnt,     w_bitcnt_nxt;
    logic [CMD_BITS-1:0]   r_cmd,        w_cmd_nxt;
    logic [ADC_BITS-1:0]   r_out_sr,     w_out_sr_nxt;
    logic                  r_miso,       w_miso_nxt;
    logic                  r_oe,         w_oe_nxt;
    logic                  r_req_valid,  w_req_valid_nxt;
    logic [2:0]            r_req_chan,   w_req_chan_nxt;
    logic                  r_req_sgl,    w_req_sgl_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  r_armed,      w_armed_nxt;

    // cmd = {SGL, D2, D1, D0}; the pair partner of channel D is D with D0 flipped.
    logic [ADC_BITS-1:0] w_in_pos;
    logic [ADC_BITS-1:0] w_in_neg;
    logic [ADC_BITS:0]   w_diff;
    logic [ADC_BITS-1:0] w_value;

    assign w_in_pos = ch_sel(i_ch_data, r_cmd[2:0]);
    assign w_in_neg = ch_sel(i_ch_data, {r_cmd[2:1], ~r_cmd[0]});
    assign w_diff   = {1'b0, w_in_pos} - {1'b0, w_in_neg};
    assign w_value  = r_cmd[3] ? w_in_pos :
                      (w_diff[ADC_BITS] ? '0 : w_diff[ADC_BITS-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_cmd        <= '0;
            r_out_sr     <= '0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_chan   <= '0;
            r_req_sgl    <= 1'b0;
            r_frame_done <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_cmd        <= w_cmd_nxt;
            r_out_sr     <= w_out_sr_nxt;
            r_miso       <= w_miso_nxt;
            r_oe         <= w_oe_nxt;
            r_req_valid  <= w_req_valid_nxt;
            r_req_chan   <= w_req_chan_nxt;
            r_req_sgl    <= w_req_sgl_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_armed      <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bitcnt_nxt     = r_bitcnt;
        w_cmd_nxt        = r_cmd;
        w_out_sr_nxt     = r_out_sr;
        w_miso_nxt       = r_miso;
        w_oe_nxt         = r_oe;
        w_req_valid_nxt  = 1'b0;
        w_req_chan_nxt   = r_req_chan;
        w_req_sgl_nxt    = r_req_sgl;
        w_frame_done_nxt = 1'b0;
        w_armed_nxt      = r_armed | w_cs_n_s;

        // Deselect beats every SCK edge, in every state, including SNAP.
        if (w_cs_n_s) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_miso_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_armed) begin
                        w_state_nxt  = WAIT_ST;
                        w_oe_nxt     = 1'b1;
                        w_miso_nxt   = 1'b0;
                        w_cmd_nxt    = '0;
                        w_bitcnt_nxt = '0;
                    end
                end
                WAIT_ST: begin
                    if (w_sck_rise && w_mosi_s) begin
                        w_state_nxt  = CMD;
                        w_bitcnt_nxt = '0;
                    end
                end
                CMD: begin
                    if (w_sck_rise) begin
                        w_cmd_nxt = {r_cmd[CMD_BITS-2:0], w_mosi_s};
                        if (r_bitcnt == 4'(CMD_BITS - 1)) begin
                            w_state_nxt = SNAP;
                        end else begin
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                        end
                    end
                end
                SNAP: begin
                    // req_valid is a one-cycle strobe with no backpressure;
                    // req_chan/req_sgl hold until the next strobe.
                    w_out_sr_nxt    = w_value;
                    w_req_valid_nxt = 1'b1;
                    w_req_chan_nxt  = r_cmd[2:0];
                    w_req_sgl_nxt   = r_cmd[3];
                    w_state_nxt     = NULL;
                end
                NULL: begin
                    if (w_sck_fall) begin
                        w_miso_nxt   = 1'b0;
                        w_state_nxt  = MSB;
                        w_bitcnt_nxt = 4'(ADC_BITS - 1);
                    end
                end
                MSB: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = r_out_sr[r_bitcnt];
                        if (r_bitcnt == 4'd0) begin
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = LSB;
                            w_bitcnt_nxt     = 4'd1;
                        end else begin
                            w_bitcnt_nxt = r_bitcnt - 4'd1;
                        end
                    end
                end
                LSB: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = r_out_sr[r_bitcnt];
                        if (r_bitcnt == 4'(ADC_BITS - 1)) begin
                            w_state_nxt = ZERO;
                        end else begin
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                        end
                    end
                end
                ZERO: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign spi.spi_miso    = r_miso;
    assign spi.spi_miso_oe = r_oe;
    assign o_req_valid     = r_req_valid;
    assign o_req_chan      = r_req_chan;
    assign o_req_sgl       = r_req_sgl;
    assign o_frame_done    = r_frame_done;
    assign o_state         = r_state;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Bench for the MCP3008 responder: a bit-banging SPI master feeds directed and
// random frames while monitors compare MISO, requests and frame_done against queues.
module tb_mcp3008_spi_responder;
    import mcp3008_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcp3008_spi_responder_if spi_if ();

    logic [79:0] ch_data;
    logic        req_valid;
    logic [2:0]  req_chan;
    logic        req_sgl;
    logic        frame_done;
    state_t      dbg_state;

    mcp3008_spi_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .ADC_BITS    (10)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ch_data    (ch_data),
        .spi          (spi_if),
        .o_req_valid  (req_valid),
        .o_req_chan   (req_chan),
        .o_req_sgl    (req_sgl),
        .o_frame_done (frame_done),
        .o_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         ch[8];
    logic [1:0] exp_q[$];        // {oe, miso} expected at each SCK rise with cs low
    logic [3:0] exp_req_q[$];    // {sgl, chan}
    int         exp_done_q[$];   // rise index within the frame when frame_done fires
    int         n_checks = 0;
    int         n_fail   = 0;
    int         rise_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void load_ch();
        ch_data = '0;
        for (int k = 7; k >= 0; k--) ch_data = {ch_data[69:0], 10'(ch[k])};
    endfunction

    function automatic void randomize_ch();
        for (int k = 0; k < 8; k++) ch[k] = $urandom_range(0, 1023);
    endfunction

    function automatic int model_value(input bit sgl, input int d);
        int p, plus, minus;
        if (sgl) return ch[d];
        p = d / 2;
        if (d % 2 == 0) begin plus = ch[2*p];   minus = ch[2*p+1]; end
        else            begin plus = ch[2*p+1]; minus = ch[2*p];   end
        return (plus >= minus) ? plus - minus : 0;
    endfunction

    // Bit the master sees on rise r: null after the command, B9..B0, B1..B9, zeros.
    function automatic bit exp_bit(input int value, input int lead, input int r);
        int m;
        m = r - (lead + 6);
        if (m >= 1 && m <= 10)  return bit'((value >> (10 - m)) & 1);
        if (m >= 11 && m <= 19) return bit'((value >> (m - 10)) & 1);
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_cycle(input bit b);
        spi_if.spi_mosi = b;
        wait_clk(HALF);
        spi_if.spi_sck = 1'b1;
        wait_clk(HALF);
        spi_if.spi_sck = 1'b0;
    endtask

    task automatic frame(input int lead, input bit sgl, input int d, input int ncyc,
                         input bit sck_hi, input bit keep_cs, input bit respond);
        int value;
        bit b;
        load_ch();
        value = model_value(sgl, d);
        for (int r = 1; r <= ncyc; r++)
            exp_q.push_back(respond ? {1'b1, exp_bit(value, lead, r)} : 2'b00);
        if (respond && ncyc >= lead + 5)  exp_req_q.push_back({sgl, 3'(d)});
        if (respond && ncyc >= lead + 15) exp_done_q.push_back(lead + 15);

        if (sck_hi) begin
            spi_if.spi_sck = 1'b1;
            wait_clk(4);
        end
        spi_if.spi_cs = 1'b0;
        wait_clk(HALF);
        if (sck_hi) begin
            spi_if.spi_sck = 1'b0;
            wait_clk(HALF);
        end
        for (int i = 0; i < ncyc; i++) begin
            if (i < lead)           b = 1'b0;
            else if (i == lead)     b = 1'b1;
            else if (i == lead + 1) b = sgl;
            else if (i <= lead + 4) b = bit'((d >> (lead + 4 - i)) & 1);
            else                    b = 1'b0;
            sck_cycle(b);
            if (i + 1 == lead + 6) begin
                randomize_ch();
                load_ch();
            end
        end
        if (!keep_cs) begin
            wait_clk(HALF);
            spi_if.spi_cs = 1'b1;
            wait_clk(SYNC_STAGES + 1);
            check("oe_release", 32'(spi_if.spi_miso_oe), 32'd0);
            wait_clk(HALF);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge spi_if.spi_sck or posedge spi_if.spi_cs) begin
        if (spi_if.spi_cs !== 1'b0) begin
            rise_cnt = 0;
        end else begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL miso_extra: rise %0d got 0x%0h expected none", rise_cnt,
                         {spi_if.spi_miso_oe, spi_if.spi_miso});
            end else begin
                check("miso", 32'({spi_if.spi_miso_oe, spi_if.spi_miso}), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (req_valid === 1'b1) begin
            if (exp_req_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_extra: got sgl=%0d chan=%0d expected none", req_sgl, req_chan);
            end else begin
                check("req", 32'({req_sgl, req_chan}), 32'(exp_req_q.pop_front()));
            end
        end
        if (frame_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_extra: got frame_done at rise %0d expected none", rise_cnt);
            end else begin
                check("frame_done_pos", 32'(rise_cnt), 32'(exp_done_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lead, d, ncyc;
        bit sgl;
        spi_if.spi_sck  = 1'b0;
        spi_if.spi_cs   = 1'b1;
        spi_if.spi_mosi = 1'b0;
        randomize_ch();
        load_ch();
        wait_clk(3);
        check("rst_oe",    32'(spi_if.spi_miso_oe), 32'd0);
        check("rst_miso",  32'(spi_if.spi_miso),    32'd0);
        check("rst_req_v", 32'(req_valid),          32'd0);
        check("rst_req",   32'({req_sgl, req_chan}), 32'd0);
        check("rst_done",  32'(frame_done),         32'd0);
        check("rst_state", 32'(dbg_state),          32'(IDLE));
        rst_n = 1'b1;
        wait_clk(8);

        ch[0] = 'h2A5;
        frame(0, 1'b1, 0, 17, 1'b0, 1'b0, 1'b1);
        randomize_ch(); ch[7] = 'h3FF;
        frame(3, 1'b1, 7, 20, 1'b0, 1'b0, 1'b1);
        randomize_ch(); ch[0] = 'h300; ch[1] = 'h100;
        frame(0, 1'b0, 0, 17, 1'b0, 1'b0, 1'b1);
        randomize_ch(); ch[0] = 'h300; ch[1] = 'h100;
        frame(0, 1'b0, 1, 17, 1'b0, 1'b0, 1'b1);
        randomize_ch(); ch[2] = 'h201;
        frame(0, 1'b1, 2, 26, 1'b0, 1'b0, 1'b1);

        // Abort after two command bits, then a frame starting with SCK high.
        frame(0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b1);
        randomize_ch(); ch[3] = 'h155;
        frame(0, 1'b1, 3, 17, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of the MSB phase with cs held low throughout.
        randomize_ch();
        frame(0, 1'b1, 5, 10, 1'b0, 1'b1, 1'b1);
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check("midrst_oe",    32'(spi_if.spi_miso_oe), 32'd0);
        check("midrst_miso",  32'(spi_if.spi_miso),    32'd0);
        check("midrst_req",   32'({req_valid, req_sgl, req_chan}), 32'd0);
        check("midrst_done",  32'(frame_done),         32'd0);
        check("midrst_state", 32'(dbg_state),          32'(IDLE));
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(8);
        frame(0, 1'b1, 2, 18, 1'b0, 1'b0, 1'b0);
        randomize_ch();
        frame(0, 1'b0, 6, 17, 1'b0, 1'b0, 1'b1);

        for (int it = 0; it < 14; it++) begin
            randomize_ch();
            lead = $urandom_range(0, 3);
            sgl  = bit'($urandom_range(0, 1));
            d    = $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) ncyc = $urandom_range(1, lead + 4);
            else                           ncyc = $urandom_range(lead + 5, lead + 24);
            frame(lead, sgl, d, ncyc, bit'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        wait_clk(20);
        check("miso_q_empty", 32'(exp_q.size()),      32'd0);
        check("req_q_empty",  32'(exp_req_q.size()),  32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
